// File: rtl/wb_writer_pkg.sv
// Shared writeback-stage definitions: result-source codes, default widths and the entry type
// used by both the MEM/WB register and the long-op pending buffer.
package wb_writer_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned REGW_DEF = 5;

  localparam logic [1:0] RES_ALU  = 2'b00;
  localparam logic [1:0] RES_LOAD = 2'b01;
  localparam logic [1:0] RES_PC4  = 2'b10;

  typedef struct packed {
    logic                valid;
    logic [REGW_DEF-1:0] rd;
    logic [XLEN_DEF-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_writer_if.sv
// MEM-stage inputs, long-op handshake, register-file write port and hazard/forwarding outputs.
interface wb_writer_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned REGW = 5
);
  logic            flush;
  logic            mem_valid;
  logic            mem_reg_write;
  logic [REGW-1:0] mem_rd;
  logic [1:0]      mem_result_src;
  logic [XLEN-1:0] mem_alu_result;
  logic [XLEN-1:0] mem_read_data;
  logic [XLEN-1:0] mem_pc_plus4;
  logic            lo_valid;
  logic [REGW-1:0] lo_rd;
  logic [XLEN-1:0] lo_data;
  logic            lo_ready;
  logic            WE3;
  logic [REGW-1:0] A3;
  logic [XLEN-1:0] WD3;
  logic            fwd_valid;
  logic [REGW-1:0] fwd_rd;
  logic [XLEN-1:0] fwd_data;
  logic            pend_valid;
  logic [REGW-1:0] pend_rd;

  modport master (
    output flush, mem_valid, mem_reg_write, mem_rd, mem_result_src, mem_alu_result,
           mem_read_data, mem_pc_plus4, lo_valid, lo_rd, lo_data,
    input  lo_ready, WE3, A3, WD3, fwd_valid, fwd_rd, fwd_data, pend_valid, pend_rd
  );

  modport slave (
    input  flush, mem_valid, mem_reg_write, mem_rd, mem_result_src, mem_alu_result,
           mem_read_data, mem_pc_plus4, lo_valid, lo_rd, lo_data,
    output lo_ready, WE3, A3, WD3, fwd_valid, fwd_rd, fwd_data, pend_valid, pend_rd
  );
endinterface

// File: rtl/wb_pending_buf.sv
// One-entry holding buffer for late long-op results; drains into the write port whenever the
// pipeline leaves it free. Results aimed at x0 are accepted and dropped.
module wb_pending_buf
  import wb_writer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned REGW = REGW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            lo_valid,
  input  logic [REGW-1:0] lo_rd,
  input  logic [XLEN-1:0] lo_data,
  output logic            lo_ready,
  input  logic            drain_en,
  output wb_entry_t       entry
);

  wb_entry_t buf_q, buf_d;

  // No refill while occupied, so the drain cycle also reports not-ready.
  assign lo_ready = ~buf_q.valid & ~rst;
  assign entry    = buf_q;

  always_comb begin
    buf_d = buf_q;
    if (drain_en) begin
      buf_d.valid = 1'b0;
    end
    if (lo_valid && lo_ready && (lo_rd != '0)) begin
      buf_d.valid = 1'b1;
      buf_d.rd    = lo_rd;
      buf_d.data  = lo_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/wb_writer.sv
// Writeback stage: MEM/WB capture with result select, then drives the register-file write port,
// giving the pipeline priority over the pending long-op result.
module wb_writer
  import wb_writer_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF,
  parameter int unsigned REGW = REGW_DEF
) (
  input logic         clk,
  input logic         rst,
  wb_writer_if.slave  bus
);

  wb_entry_t       wb_q, wb_d;
  wb_entry_t       pend;
  logic [XLEN-1:0] result;

  always_comb begin
    case (bus.mem_result_src)
      RES_LOAD: result = bus.mem_read_data;
      RES_PC4:  result = bus.mem_pc_plus4;
      default:  result = bus.mem_alu_result;
    endcase
  end

  always_comb begin
    wb_d.valid = bus.mem_valid & bus.mem_reg_write & (bus.mem_rd != '0) & ~bus.flush;
    wb_d.rd    = bus.mem_rd;
    wb_d.data  = result;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q <= '0;
    end else begin
      wb_q <= wb_d;
    end
  end

  wb_pending_buf #(
    .XLEN (XLEN),
    .REGW (REGW)
  ) u_pend (
    .clk      (clk),
    .rst      (rst),
    .lo_valid (bus.lo_valid),
    .lo_rd    (bus.lo_rd),
    .lo_data  (bus.lo_data),
    .lo_ready (bus.lo_ready),
    .drain_en (~wb_q.valid),
    .entry    (pend)
  );

  // Both sources exclude rd==0 on entry, so x0 is never written.
  always_comb begin
    bus.WE3 = 1'b0;
    bus.A3  = '0;
    bus.WD3 = '0;
    if (wb_q.valid) begin
      bus.WE3 = 1'b1;
      bus.A3  = wb_q.rd;
      bus.WD3 = wb_q.data;
    end else if (pend.valid) begin
      bus.WE3 = 1'b1;
      bus.A3  = pend.rd;
      bus.WD3 = pend.data;
    end
  end

  assign bus.fwd_valid  = bus.WE3;
  assign bus.fwd_rd     = bus.A3;
  assign bus.fwd_data   = bus.WD3;
  assign bus.pend_valid = pend.valid;
  assign bus.pend_rd    = pend.valid ? pend.rd : '0;

endmodule

// File: tb/tb_wb_writer.sv
// Directed scenarios plus a randomized run against a queue-based model of the writeback port.
module tb_wb_writer;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } pend_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wb_writer_if #(.XLEN(32), .REGW(5)) bus ();

  wb_writer #(.XLEN(32), .REGW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.flush          = 1'b0;
    bus.mem_valid      = 1'b0;
    bus.mem_reg_write  = 1'b0;
    bus.mem_rd         = '0;
    bus.mem_result_src = 2'b00;
    bus.mem_alu_result = '0;
    bus.mem_read_data  = '0;
    bus.mem_pc_plus4   = '0;
    bus.lo_valid       = 1'b0;
    bus.lo_rd          = '0;
    bus.lo_data        = '0;
  endtask

  task automatic mem_write(input logic [4:0] rd, input logic [31:0] val);
    bus.mem_valid      = 1'b1;
    bus.mem_reg_write  = 1'b1;
    bus.mem_rd         = rd;
    bus.mem_result_src = 2'b00;
    bus.mem_alu_result = val;
  endtask

  // Advance one clock; outputs are then sampled mid-cycle on the falling edge.
  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    mem_write(5'd5, 32'h55);
    bus.lo_valid = 1'b1;
    bus.lo_rd    = 5'd3;
    bus.lo_data  = 32'h33;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if ({bus.WE3, bus.A3, bus.WD3} !== 38'd0) begin
        errors++;
        $display("FAIL reset_port: got %b/%0d/%h want 0/0/0", bus.WE3, bus.A3, bus.WD3);
      end
      checks++;
      if ({bus.lo_ready, bus.pend_valid, bus.pend_rd} !== 7'd0) begin
        errors++;
        $display("FAIL reset_lo: got ready=%b pend=%b/%0d want 0/0/0",
                 bus.lo_ready, bus.pend_valid, bus.pend_rd);
      end
    end
    rst = 1'b0;
    idle();
    #1;
    checks++;
    if (bus.lo_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b want 1", bus.lo_ready);
    end
  endtask

  task automatic test_result_mux();
    logic [4:0]  rds [4] = '{5'd5, 5'd6, 5'd7, 5'd8};
    logic [1:0]  srcs[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [31:0] want[4] = '{32'h11, 32'h22, 32'h33, 32'h44};
    for (int i = 0; i < 4; i++) begin
      bus.mem_valid      = 1'b1;
      bus.mem_reg_write  = 1'b1;
      bus.mem_rd         = rds[i];
      bus.mem_result_src = srcs[i];
      bus.mem_alu_result = (srcs[i] == 2'b00 || srcs[i] == 2'b11) ? want[i] : 32'hAAAA_0000;
      bus.mem_read_data  = (srcs[i] == 2'b01) ? want[i] : 32'hBBBB_0000;
      bus.mem_pc_plus4   = (srcs[i] == 2'b10) ? want[i] : 32'hCCCC_0000;
      cyc();
      checks++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, rds[i], want[i]}) begin
        errors++;
        $display("FAIL mux_src%0d: got %b/%0d/%h want 1/%0d/%h",
                 srcs[i], bus.WE3, bus.A3, bus.WD3, rds[i], want[i]);
      end
      checks++;
      if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== {1'b1, rds[i], want[i]}) begin
        errors++;
        $display("FAIL mux_fwd%0d: got %b/%0d/%h want 1/%0d/%h",
                 i, bus.fwd_valid, bus.fwd_rd, bus.fwd_data, rds[i], want[i]);
      end
    end
    idle();
    cyc();
    checks++;
    if (bus.WE3 !== 1'b0) begin
      errors++;
      $display("FAIL mux_idle: got WE3=%b want 0", bus.WE3);
    end
  endtask

  task automatic test_long_op_idle();
    idle();
    bus.lo_valid = 1'b1;
    bus.lo_rd    = 5'd9;
    bus.lo_data  = 32'hDEAD;
    cyc();
    idle();
    checks++;
    if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, 5'd9, 32'hDEAD}) begin
      errors++;
      $display("FAIL lo_write: got %b/%0d/%h want 1/9/dead", bus.WE3, bus.A3, bus.WD3);
    end
    checks++;
    if ({bus.pend_valid, bus.pend_rd, bus.lo_ready} !== {1'b1, 5'd9, 1'b0}) begin
      errors++;
      $display("FAIL lo_pend: got pend=%b/%0d ready=%b want 1/9/0",
               bus.pend_valid, bus.pend_rd, bus.lo_ready);
    end
    cyc();
    checks++;
    if ({bus.pend_valid, bus.lo_ready, bus.WE3} !== 3'b010) begin
      errors++;
      $display("FAIL lo_drained: got pend=%b ready=%b we=%b want 0/1/0",
               bus.pend_valid, bus.lo_ready, bus.WE3);
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0]  exp_rd [4] = '{5'd1, 5'd2, 5'd3, 5'd10};
    logic [31:0] exp_wd [4] = '{32'h101, 32'h102, 32'h103, 32'hA10};
    idle();
    bus.lo_valid = 1'b1;
    bus.lo_rd    = 5'd10;
    bus.lo_data  = 32'hA10;
    for (int i = 0; i < 4; i++) begin
      if (i < 3) mem_write(exp_rd[i], exp_wd[i]);
      else idle();
      cyc();
      bus.lo_valid = 1'b0;
      checks++;
      if ({bus.WE3, bus.A3, bus.WD3} !== {1'b1, exp_rd[i], exp_wd[i]}) begin
        errors++;
        $display("FAIL b2b_write%0d: got %b/%0d/%h want 1/%0d/%h",
                 i, bus.WE3, bus.A3, bus.WD3, exp_rd[i], exp_wd[i]);
      end
      checks++;
      if ({bus.lo_ready, bus.pend_valid, bus.pend_rd} !== {1'b0, 1'b1, 5'd10}) begin
        errors++;
        $display("FAIL b2b_pend%0d: got ready=%b pend=%b/%0d want 0/1/10",
                 i, bus.lo_ready, bus.pend_valid, bus.pend_rd);
      end
    end
    idle();
    cyc();
    checks++;
    if ({bus.lo_ready, bus.pend_valid, bus.WE3} !== 3'b100) begin
      errors++;
      $display("FAIL b2b_done: got ready=%b pend=%b we=%b want 1/0/0",
               bus.lo_ready, bus.pend_valid, bus.WE3);
    end
  endtask

  task automatic test_suppression();
    for (int i = 0; i < 3; i++) begin
      idle();
      case (i)
        0: mem_write(5'd0, 32'h99);
        1: begin
          mem_write(5'd4, 32'h44);
          bus.flush = 1'b1;
        end
        default: begin
          mem_write(5'd4, 32'h44);
          bus.mem_reg_write = 1'b0;
        end
      endcase
      cyc();
      checks++;
      if (bus.WE3 !== 1'b0) begin
        errors++;
        $display("FAIL suppress%0d: got WE3=%b A3=%0d want WE3=0", i, bus.WE3, bus.A3);
      end
    end
    idle();
    bus.lo_valid = 1'b1;
    bus.lo_rd    = 5'd0;
    bus.lo_data  = 32'hBAD0;
    #1;
    checks++;
    if (bus.lo_ready !== 1'b1) begin
      errors++;
      $display("FAIL lo_x0_ready: got %b want 1", bus.lo_ready);
    end
    cyc();
    idle();
    checks++;
    if ({bus.WE3, bus.pend_valid, bus.lo_ready} !== 3'b001) begin
      errors++;
      $display("FAIL lo_x0_drop: got we=%b pend=%b ready=%b want 0/0/1",
               bus.WE3, bus.pend_valid, bus.lo_ready);
    end
  endtask

  task automatic test_reset_discard();
    idle();
    mem_write(5'd3, 32'h333);
    bus.lo_valid = 1'b1;
    bus.lo_rd    = 5'd12;
    bus.lo_data  = 32'hC12;
    cyc();
    idle();
    checks++;
    if ({bus.pend_valid, bus.pend_rd, bus.A3} !== {1'b1, 5'd12, 5'd3}) begin
      errors++;
      $display("FAIL discard_setup: got pend=%b/%0d A3=%0d want 1/12/3",
               bus.pend_valid, bus.pend_rd, bus.A3);
    end
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ({bus.WE3, bus.pend_valid} !== 2'b00) begin
        errors++;
        $display("FAIL discard%0d: got we=%b A3=%0d pend=%b want 0/-/0",
                 i, bus.WE3, bus.A3, bus.pend_valid);
      end
      cyc();
    end
  endtask

  task automatic test_random();
    bit          m_v;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    pend_t       q[$];
    bit          acc;
    logic [37:0] exp_port;
    logic [5:0]  exp_pend;
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    m_v = 1'b0;
    m_rd = '0;
    m_data = '0;
    for (int i = 0; i < 400; i++) begin
      rst                = ($urandom_range(0, 49) == 0);
      bus.flush          = ($urandom_range(0, 3) == 0);
      bus.mem_valid      = ($urandom_range(0, 3) != 0);
      bus.mem_reg_write  = ($urandom_range(0, 4) != 0);
      bus.mem_rd         = 5'($urandom_range(0, 7));
      bus.mem_result_src = 2'($urandom_range(0, 3));
      bus.mem_alu_result = $urandom;
      bus.mem_read_data  = $urandom;
      bus.mem_pc_plus4   = $urandom;
      bus.lo_valid       = ($urandom_range(0, 2) == 0);
      bus.lo_rd          = 5'($urandom_range(0, 7));
      bus.lo_data        = $urandom;
      #1;
      checks++;
      if (bus.lo_ready !== ((q.size() == 0) && !rst)) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", i, bus.lo_ready,
                 (q.size() == 0) && !rst);
      end
      if (rst) begin
        m_v = 1'b0;
        q.delete();
      end else begin
        acc = bus.lo_valid && (q.size() == 0);
        if (!m_v && q.size() != 0) void'(q.pop_front());
        if (acc && bus.lo_rd != 0) q.push_back('{rd: bus.lo_rd, data: bus.lo_data});
        m_v    = bus.mem_valid && bus.mem_reg_write && (bus.mem_rd != 0) && !bus.flush;
        m_rd   = bus.mem_rd;
        m_data = (bus.mem_result_src == 2'd1) ? bus.mem_read_data :
                 (bus.mem_result_src == 2'd2) ? bus.mem_pc_plus4  : bus.mem_alu_result;
      end
      cyc();
      if (m_v)              exp_port = {1'b1, m_rd, m_data};
      else if (q.size() != 0) exp_port = {1'b1, q[0].rd, q[0].data};
      else                  exp_port = '0;
      exp_pend = (q.size() != 0) ? {1'b1, q[0].rd} : 6'd0;
      checks++;
      if ({bus.WE3, bus.A3, bus.WD3} !== exp_port) begin
        errors++;
        $display("FAIL rand_port[%0d]: got %b/%0d/%h want %b/%0d/%h", i, bus.WE3, bus.A3,
                 bus.WD3, exp_port[37], exp_port[36:32], exp_port[31:0]);
      end
      checks++;
      if ({bus.fwd_valid, bus.fwd_rd, bus.fwd_data} !== exp_port) begin
        errors++;
        $display("FAIL rand_fwd[%0d]: got %b/%0d/%h want %b/%0d/%h", i, bus.fwd_valid,
                 bus.fwd_rd, bus.fwd_data, exp_port[37], exp_port[36:32], exp_port[31:0]);
      end
      checks++;
      if ({bus.pend_valid, bus.pend_rd} !== exp_pend) begin
        errors++;
        $display("FAIL rand_pend[%0d]: got %b/%0d want %b/%0d", i, bus.pend_valid,
                 bus.pend_rd, exp_pend[5], exp_pend[4:0]);
      end
      checks++;
      if (bus.WE3 === 1'b1 && bus.A3 === 5'd0) begin
        errors++;
        $display("FAIL rand_x0[%0d]: got WE3=1 A3=0 want no x0 write", i);
      end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    @(negedge clk);
    test_reset();
    test_result_mux();
    test_long_op_idle();
    test_back_to_back();
    test_suppression();
    test_reset_discard();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_writer.md
Name: wb_writer

Overview:
Writer end of the register-file write port (WE3/A3/WD3). The block holds the MEM/WB pipeline register and selects the writeback result. It also merges late results from a multi-cycle unit (divider/long op) through a one-entry pending buffer. It drives the register file's write port plus forwarding/scoreboard signals for the decode-stage hazard logic.

Parameters:
XLEN, 32, data width of results and WD3
REGW, 5, register index width (A3, rd fields)

Ports:
clk  in  1  clock; register file writes on negedge, so WE3/A3/WD3 must be stable across the low phase
rst  in  1  synchronous, active-high reset
flush  in  1  kill the instruction being captured from MEM this edge
mem_valid  in  1  MEM stage holds a real instruction
mem_reg_write  in  1  instruction writes rd
mem_rd  in  REGW  destination register
mem_result_src  in  2  00 ALU, 01 load data, 10 PC+4, 11 reserved (treated as ALU)
mem_alu_result  in  XLEN  ALU result
mem_read_data  in  XLEN  load data
mem_pc_plus4  in  XLEN  link value
lo_valid  in  1  long-op result offered
lo_rd  in  REGW  long-op destination
lo_data  in  XLEN  long-op result
lo_ready  out  1  long-op result accepted this edge when lo_valid&lo_ready
WE3  out  1  register file write enable
A3  out  REGW  register file write address
WD3  out  XLEN  register file write data
fwd_valid  out  1  WB value available for forwarding (equals WE3)
fwd_rd  out  REGW  equals A3
fwd_data  out  XLEN  equals WD3
pend_valid  out  1  pending buffer occupied
pend_rd  out  REGW  pending destination (hazard unit stalls readers of it)

Behaviour:
- State: MEM/WB register (wb_v, wb_rd, wb_data) plus pending buffer (buf_v, buf_rd, buf_data). Result mux is applied before capture, so wb_data holds the final value.
- Capture at each posedge:
  - wb_v <= mem_valid & mem_reg_write & (mem_rd!=0) & ~flush
  - wb_rd and wb_data are loaded unconditionally.
  - The pipeline never stalls in this block.
- Write-port selection, combinational from registered state only:
  - wb_v=1: WE3=1, A3=wb_rd, WD3=wb_data. Pipeline has priority.
  - Otherwise buf_v=1: WE3=1, A3=buf_rd, WD3=buf_data. This is a drain; buf_v clears at the next posedge.
  - Otherwise: WE3=0, A3=0, WD3=0.
- Long-op acceptance:
  - lo_ready = ~buf_v & ~rst.
  - On lo_valid & lo_ready: if lo_rd!=0, capture into the buffer; if lo_rd==0, discard it (accepted, buffer stays empty).
  - Latency: accepted at edge N, written during cycle N+1 at the earliest. It is delayed one cycle per consecutive wb_v cycle.
  - No same-edge drain-and-refill: lo_ready is low for every cycle buf_v=1, including the drain cycle.
- Same-rd conflict:
  - If wb_v and buf_v target the same rd, the pipeline value is written first and the buffer value afterwards.
  - The hazard unit must use pend_valid/pend_rd to prevent younger writers to a pending rd. This block does not reorder.
- x0: never asserts WE3 with A3=0.
- flush affects only the MEM capture. It never drops buffer contents or an in-flight lo handshake.
- Reset (rst=1 at posedge): wb_v=0, buf_v=0, wb_rd/wb_data/buf_rd/buf_data=0.
  - Outputs after that edge: WE3=0, A3=0, WD3=0, fwd_*=0, pend_valid=0, pend_rd=0.
  - lo_ready=0 while rst is high.
  - Reset asserted with buf_v=1 discards the pending result.
- Forwarding outputs are pure copies of the write port, with no extra latency.

Decomposition:
- Shared pipeline package holds:
  - result-source constants RES_ALU=2'b00, RES_LOAD=2'b01, RES_PC4=2'b10
  - XLEN/REGW defaults
  - a wb_entry typedef (valid, rd, data) used by both the MEM/WB register and the buffer
- One natural sub-module: wb_pending_buf. It is the one-entry valid/ready buffer with load, drain and discard-x0 logic. Top level holds the capture register, result mux and priority select.

Test Plan:
1. Reset with rst=1 for 2 cycles while lo_valid=1 and mem_valid=1 -> WE3=0, lo_ready=0, pend_valid=0. After release, lo_ready=1.
2. ALU, load and link capture in successive cycles: mem_rd=5/6/7 with result_src 00/01/10 and data 0x11/0x22/0x33. Next three cycles -> WE3=1 with A3,WD3 = 5,0x11; 6,0x22; 7,0x33. Checker samples on negedge.
3. Idle pipeline, lo_valid with lo_rd=9, lo_data=0xDEAD at edge N -> cycle N+1: WE3=1, A3=9, WD3=0xDEAD, pend_valid=1. Cycle N+2: pend_valid=0, lo_ready=1.
4. Long op accepted while 3 back-to-back pipeline writes (rd 1,2,3) occupy WB -> buffer holds rd=10 and lo_ready=0 for 4 cycles. rd=10 is written in the 4th cycle, after rd 1,2,3.
5. Suppression cases: mem_rd=0 with reg_write=1, flush=1 with mem_rd=4, lo_rd=0 offered -> WE3 never asserts. The lo_rd=0 handshake completes with pend_valid=0.
6. rst asserted the cycle after a long op is buffered (pend_valid=1, rd=12) -> rd=12 is never written, and pend_valid=0 after reset.
